// File: rtl/i2c_cmd_queue.sv
// Command queue in front of the I2C bus controller: filters decoder register writes,
// buffers them in a FIFO and replays them one at a time on a cmd_rqst/cmd_ack handshake.
module i2c_cmd_queue #(
    parameter int          DEPTH_LOG2 = 4,
    parameter int          TIMEOUT    = 4096,
    parameter logic [5:0]  I2C_ADDR   = 6'h3d,
    parameter logic [7:0]  I2C_TAG    = 8'h06,
    parameter logic [5:0]  FILT_ADDR  = 6'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            in_addr,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    output logic [5:0]            cmd_addr,
    output logic [31:0]           cmd_data,
    output logic                  cmd_rqst,
    input  logic                  cmd_ack,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            ovf_cnt,
    output logic [7:0]            tmo_cnt
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;

    localparam logic [TW-1:0]         TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [37:0]           mem [DEPTH];
    logic [37:0]           rd_data_q;

    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]            state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [6:0]            last_filt_q, last_filt_d;
    logic [7:0]            ovf_q, ovf_d;
    logic [7:0]            tmo_q, tmo_d;
    logic [5:0]            cmd_addr_q, cmd_addr_d;
    logic [31:0]           cmd_data_q, cmd_data_d;
    logic                  cmd_rqst_q, cmd_rqst_d;

    logic                  i2c_hit, filt_hit, accept;
    logic                  rd_en, wr_en;
    logic                  fifo_empty, fifo_full;
    logic [DEPTH_LOG2:0]   fifo_level;

    // Input filter: generic I2C writes need the tag; filter-select writes only on change.
    always_comb begin
        i2c_hit     = in_valid && (in_addr == I2C_ADDR) && (in_data[31:24] == I2C_TAG);
        filt_hit    = in_valid && (in_addr == FILT_ADDR) && (in_data[23:17] != last_filt_q);
        accept      = i2c_hit || filt_hit;
        last_filt_d = filt_hit ? in_data[23:17] : last_filt_q;
    end

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == FULL_LEVEL);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tmo_d      = tmo_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        cmd_rqst_d = cmd_rqst_q;
        rd_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_rqst_d = 1'b0;
                if (!fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cmd_addr_d = rd_data_q[37:32];
                cmd_data_d = rd_data_q[31:0];
                cmd_rqst_d = 1'b1;
                timer_d    = '0;
                state_d    = ST_REQ;
            end
            ST_REQ: begin
                // An ack landing on the timeout cycle wins: the entry counts as delivered.
                if (cmd_ack || (timer_q == TMO_LAST)) begin
                    if (!cmd_ack && (tmo_q != 8'hff)) begin
                        tmo_d = tmo_q + 8'd1;
                    end
                    cmd_rqst_d = 1'b0;
                    if (!fifo_empty) begin
                        rd_en   = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                cmd_rqst_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // A pop in the same cycle frees a slot, so a write at full is still kept.
    always_comb begin
        wr_en = accept && (!fifo_full || rd_en);
        ovf_d = ovf_q;
        if (accept && fifo_full && !rd_en && (ovf_q != 8'hff)) begin
            ovf_d = ovf_q + 8'd1;
        end
        wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, rd_en};
    end

    // Storage has no reset; a read and write to the same slot returns the old entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {in_addr, in_data};
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            last_filt_q <= 7'h00;
            ovf_q       <= 8'h00;
            tmo_q       <= 8'h00;
            cmd_addr_q  <= 6'h00;
            cmd_data_q  <= 32'h0;
            cmd_rqst_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            last_filt_q <= last_filt_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_rqst_q  <= cmd_rqst_d;
        end
    end

    assign cmd_addr = cmd_addr_q;
    assign cmd_data = cmd_data_q;
    assign cmd_rqst = cmd_rqst_q;
    assign level    = fifo_level;
    assign ovf_cnt  = ovf_q;
    assign tmo_cnt  = tmo_q;

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Bench for i2c_cmd_queue: directed writes feed a scoreboard queue; a monitor pops and
// compares each entry the DUT presents on cmd_rqst, while the stimulus checks level/counters.
module tb_i2c_cmd_queue;

    localparam int DL2   = 2;
    localparam int DEPTH = 4;
    localparam int TMO   = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    in_addr = '0;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic [5:0]    cmd_addr;
    logic [31:0]   cmd_data;
    logic          cmd_rqst;
    logic          cmd_ack = 1'b0;
    logic [DL2:0]  level;
    logic [7:0]    ovf_cnt;
    logic [7:0]    tmo_cnt;

    int            n_vec  = 0;
    int            n_miss = 0;
    logic [37:0]   exp_q[$];
    logic [37:0]   cur = '0;
    logic          rqst_prev = 1'b0;

    i2c_cmd_queue #(.DEPTH_LOG2(DL2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rqst(cmd_rqst), .cmd_ack(cmd_ack),
        .level(level), .ovf_cnt(ovf_cnt), .tmo_cnt(tmo_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input bit queued);
        in_addr  = a;
        in_data  = d;
        in_valid = 1'b1;
        if (queued) exp_q.push_back({a, d});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_rqst(input string name);
        int k = 0;
        while (!cmd_rqst && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_rqst) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: cmd_rqst never rose within %0d cycles", name, k);
        end
    endtask

    task automatic pulse_ack();
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
    endtask

    task automatic ack_after(input int n, input string name);
        wait_rqst(name);
        repeat (n) @(negedge clk);
        pulse_ack();
    endtask

    // Monitor: every newly presented entry must be the oldest expected one, held stable.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cmd_rqst && !rqst_prev) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_miss++;
                        $display("FAIL present: got %0h/%08h, no entry expected", cmd_addr, cmd_data);
                        cur = {cmd_addr, cmd_data};
                    end else begin
                        cur = exp_q.pop_front();
                        if ({cmd_addr, cmd_data} !== cur) begin
                            n_miss++;
                            $display("FAIL present: got %0h/%08h, expected %0h/%08h",
                                     cmd_addr, cmd_data, cur[37:32], cur[31:0]);
                            cur = {cmd_addr, cmd_data};
                        end else begin
                            $display("ok   present: %0h/%08h", cmd_addr, cmd_data);
                        end
                    end
                end else if (cmd_rqst && ({cmd_addr, cmd_data} !== cur)) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL hold: got %0h/%08h, expected %0h/%08h",
                             cmd_addr, cmd_data, cur[37:32], cur[31:0]);
                    cur = {cmd_addr, cmd_data};
                end
            end
            rqst_prev = cmd_rqst;
        end
    end

    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        chk("reset rqst", 32'(cmd_rqst), 0);
        chk("reset level", 32'(level), 0);
        chk("reset ovf", 32'(ovf_cnt), 0);
        chk("reset tmo", 32'(tmo_cnt), 0);
        chk("reset addr", 32'(cmd_addr), 0);
        chk("reset data", cmd_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single write: request rises two cycles after capture, drops the cycle after ack.
        wr(6'h3d, 32'h06AB1234, 1);
        @(negedge clk);
        chk("t1 rqst early", 32'(cmd_rqst), 0);
        @(negedge clk);
        chk("t1 rqst", 32'(cmd_rqst), 1);
        chk("t1 addr", 32'(cmd_addr), 32'h3d);
        chk("t1 data", cmd_data, 32'h06AB1234);
        repeat (5) @(negedge clk);
        pulse_ack();
        chk("t1 rqst after ack", 32'(cmd_rqst), 0);
        chk("t1 level", 32'(level), 0);

        // Three writes, first ack withheld 100 cycles.
        wr(6'h3d, 32'h06000001, 1);
        wr(6'h3d, 32'h06000002, 1);
        wr(6'h3d, 32'h06000003, 1);
        ack_after(100, "t2 wait a");
        chk("t2 level after ack a", 32'(level), 1);
        ack_after(3, "t2 wait b");
        chk("t2 level after ack b", 32'(level), 0);
        ack_after(3, "t2 wait c");
        chk("t2 rqst idle", 32'(cmd_rqst), 0);
        chk("t2 drained", 32'(exp_q.size()), 0);

        // Filter-select writes only on change; foreign address and wrong tag ignored.
        wr(6'h00, 32'h000A0000, 1);
        wr(6'h00, 32'h000A0000, 0);
        wr(6'h00, 32'h000C0000, 1);
        wr(6'h12, 32'h06FFFFFF, 0);
        wr(6'h3d, 32'h07000000, 0);
        repeat (4) @(negedge clk);
        chk("t3 level", 32'(level), 1);
        ack_after(2, "t3 wait a");
        ack_after(2, "t3 wait b");
        chk("t3 level drained", 32'(level), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(6'h00, 32'h00000000, 0);
        repeat (6) @(negedge clk);
        chk("t3 post-reset level", 32'(level), 0);
        chk("t3 post-reset rqst", 32'(cmd_rqst), 0);

        // Overflow: one presented + DEPTH stored, sixth write dropped.
        for (int i = 1; i <= 6; i++) begin
            wr(6'h3d, 32'h06000010 + 32'(i), (i <= 5));
        end
        chk("t4 level full", 32'(level), DEPTH);
        chk("t4 ovf", 32'(ovf_cnt), 1);
        in_addr  = 6'h3d;
        in_data  = 32'h06000020;
        in_valid = 1'b1;
        cmd_ack  = 1'b1;
        exp_q.push_back({6'h3d, 32'h06000020});
        @(negedge clk);
        in_valid = 1'b0;
        cmd_ack  = 1'b0;
        chk("t4 level pop+write", 32'(level), DEPTH);
        chk("t4 ovf pop+write", 32'(ovf_cnt), 1);
        for (int i = 0; i < 5; i++) begin
            ack_after(1, "t4 drain");
        end
        chk("t4 level drained", 32'(level), 0);
        chk("t4 drained", 32'(exp_q.size()), 0);

        // Timeout: never ack the first entry.
        wr(6'h3d, 32'h06000055, 1);
        wr(6'h3d, 32'h06000066, 1);
        wait_rqst("t5 wait");
        cnt = 0;
        while (cmd_rqst && cnt < 4 * TMO) begin
            @(negedge clk);
            cnt++;
        end
        chk("t5 rqst high cycles", 32'(cnt), TMO);
        chk("t5 tmo", 32'(tmo_cnt), 1);
        @(negedge clk);
        chk("t5 next loaded", 32'(cmd_rqst), 1);

        // Async reset during REQ with three stored entries.
        wr(6'h3d, 32'h06000077, 1);
        wr(6'h3d, 32'h06000088, 1);
        wr(6'h3d, 32'h06000099, 1);
        chk("t6 level before", 32'(level), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 rqst", 32'(cmd_rqst), 0);
        chk("t6 level", 32'(level), 0);
        chk("t6 ovf", 32'(ovf_cnt), 0);
        chk("t6 tmo", 32'(tmo_cnt), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6 level after", 32'(level), 0);
        chk("t6 rqst after", 32'(cmd_rqst), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
